ldstr_reg_file: RTL and testbench
=================================

Name: ldstr_reg_file

Overview:
- Parametrised successor to the single load/store register: a bank of DEPTH registers, each W bits wide.
- Two write ports (load-enabled) and two read ports.
- Optional hard-wired zero register and optional write-to-read bypass.
- Sits in the processor datapath as the general-purpose register bank; replaces per-register instances of the single load/store register.

Parameters:
- W, 8, data width of each register in bits.
- DEPTH, 8, number of registers; legal range 2..256.
- AW, $clog2(DEPTH), address width; derived, never overridden.
- ZERO_REG, 0, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary.
- BYPASS, 1, 1 = a read of an address being written this cycle returns the write data; 0 = read returns the stored value.

Ports:
- clk  input  1  clock; all register updates on the falling edge.
- clr  input  1  asynchronous active-low reset; clears every register.
- load0  input  1  write enable, port 0, active-high.
- waddr0  input  AW  write address, port 0.
- in0  input  W  write data, port 0.
- load1  input  1  write enable, port 1, active-high.
- waddr1  input  AW  write address, port 1.
- in1  input  W  write data, port 1.
- raddr_a  input  AW  read address, port A.
- raddr_b  input  AW  read address, port B.
- out_a  output  W  read data, port A; combinational.
- out_b  output  W  read data, port B; combinational.

Behaviour:
- Reset:
  - clr=0 clears all DEPTH registers to 0 immediately, without waiting for a clock edge.
  - While clr=0, registers stay 0 and all writes are ignored.
  - With no writes pending, out_a and out_b read 0 during reset.
- Reset release: the first write takes effect on the first falling clk edge with clr=1.
- Write (falling edge of clk, clr=1):
  - If loadN=1 and waddrN<DEPTH, reg[waddrN] <= inN.
  - If loadN=0, the register holds its value.
  - Latency: written data is visible through the storage path immediately after that falling edge.
- Write collision: if load0=load1=1 and waddr0==waddr1, port 0 wins; port 1's data is discarded for that edge.
- Different-address dual write: both registers update on the same edge.
- Out-of-range address: writes to waddrN>=DEPTH (non-power-of-2 DEPTH) are dropped; no other register is modified.
- Read (combinational):
  - outX = reg[raddrX].
  - raddrX>=DEPTH returns 0.
  - Both read ports may address the same register.
- Bypass (BYPASS=1, clr=1):
  - If loadN=1 and waddrN==raddrX, outX = inN.
  - Port 0 has priority when both write ports match raddrX.
  - With BYPASS=0, outX shows the old value until the falling edge.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, including under bypass.
  - A port-0 write to address 0 does not block a port-1 write to a different address.
- Arithmetic: none; data passes through unchanged, and no width conversion is performed.

Test Plan:
- Reset: write 0xA5 to reg3; assert clr=0 mid-cycle, between edges -> out_a (raddr_a=3) reads 0x00 at once, before any clk edge; a write with load0=1 during clr=0 leaves reg3 at 0.
- Basic write/read:
  - load0=1, waddr0=5, in0=0x3C; one falling edge -> raddr_a=5 gives 0x3C.
  - load0=0, in0=0xFF; next edge -> still 0x3C.
- Dual write and collision:
  - waddr0=2/in0=0x11 with waddr1=4/in1=0x22 -> reg2=0x11, reg4=0x22.
  - Then both ports to addr 6 with in0=0x77, in1=0x88 -> reg6=0x77.
- Bypass:
  - BYPASS=1, reg1=0x10; drive load1=1, waddr1=1, in1=0x99 before the edge -> out_b (raddr_b=1) = 0x99 pre-edge.
  - BYPASS=0, same stimulus -> 0x10 pre-edge, 0x99 post-edge.
- Zero register: ZERO_REG=1; load0=1, waddr0=0, in0=0xFF, with bypass active -> out_a (raddr_a=0) = 0x00 before and after the edge.
- Non-power-of-2 depth: DEPTH=6, AW=3; write waddr0=7, in0=0x5A -> reg0..reg5 unchanged; raddr_a=7 reads 0x00.

Source files
------------

// File: rtl/ldstr_reg_file.sv
// Multi-ported load/store register bank: two write ports, two read ports,
// falling-edge storage with optional zero register and write bypass.
`timescale 1ns/1ps
module ldstr_reg_file #(
   parameter int W        = 8,
   parameter int DEPTH    = 8,
   parameter int AW       = $clog2(DEPTH),
   parameter bit ZERO_REG = 1'b0,
   parameter bit BYPASS   = 1'b1
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          load0,
   input  logic [AW-1:0] waddr0,
   input  logic [W-1:0]  in0,
   input  logic          load1,
   input  logic [AW-1:0] waddr1,
   input  logic [W-1:0]  in1,
   input  logic [AW-1:0] raddr_a,
   input  logic [AW-1:0] raddr_b,
   output logic [W-1:0]  out_a,
   output logic [W-1:0]  out_b
);

   logic [W-1:0] regs_q [DEPTH];
   logic [W-1:0] regs_d [DEPTH];
   logic         we0;
   logic         we1;

   function automatic logic valid_addr(input logic [AW-1:0] a);
      logic ok;
      ok = (int'(a) < DEPTH);
      if (ZERO_REG && (a == '0))
         ok = 1'b0;
      return ok;
   endfunction

   always_comb begin
      we0 = load0 && valid_addr(waddr0);
      we1 = load1 && valid_addr(waddr1);
   end

   // Port 1 is applied first so port 0 overrides it on a collision.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         regs_d[i] = regs_q[i];
         if (we1 && (int'(waddr1) == i))
            regs_d[i] = in1;
         if (we0 && (int'(waddr0) == i))
            regs_d[i] = in0;
      end
   end

   always_ff @(negedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < DEPTH; i++)
            regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            regs_q[i] <= regs_d[i];
      end
   end

   function automatic logic [W-1:0] rd_port(input logic [AW-1:0] ra);
      logic [W-1:0] rd;
      rd = '0;
      if (int'(ra) < DEPTH)
         rd = regs_q[ra];
      if (BYPASS && clr) begin
         if (we1 && (waddr1 == ra))
            rd = in1;
         if (we0 && (waddr0 == ra))
            rd = in0;
      end
      if (ZERO_REG && (ra == '0))
         rd = '0;
      return rd;
   endfunction

   always_comb begin
      out_a = rd_port(raddr_a);
      out_b = rd_port(raddr_b);
   end

endmodule

// File: tb/tb_ldstr_reg_file.sv
// Directed bench for ldstr_reg_file: default, no-bypass, zero-register
// and depth-6 variants share one stimulus stream.
`timescale 1ns/1ps
module tb_ldstr_reg_file;

   logic       clk;
   logic       clr;
   logic       load0;
   logic [2:0] waddr0;
   logic [7:0] in0;
   logic       load1;
   logic [2:0] waddr1;
   logic [7:0] in1;
   logic [2:0] raddr_a;
   logic [2:0] raddr_b;

   logic [7:0] df_a, df_b;
   logic [7:0] nb_a, nb_b;
   logic [7:0] zr_a, zr_b;
   logic [7:0] d6_a, d6_b;

   int checks;
   int failures;

   ldstr_reg_file u_df (
      .clk(clk), .clr(clr),
      .load0(load0), .waddr0(waddr0), .in0(in0),
      .load1(load1), .waddr1(waddr1), .in1(in1),
      .raddr_a(raddr_a), .raddr_b(raddr_b),
      .out_a(df_a), .out_b(df_b)
   );

   ldstr_reg_file #(.BYPASS(1'b0)) u_nb (
      .clk(clk), .clr(clr),
      .load0(load0), .waddr0(waddr0), .in0(in0),
      .load1(load1), .waddr1(waddr1), .in1(in1),
      .raddr_a(raddr_a), .raddr_b(raddr_b),
      .out_a(nb_a), .out_b(nb_b)
   );

   ldstr_reg_file #(.ZERO_REG(1'b1)) u_zr (
      .clk(clk), .clr(clr),
      .load0(load0), .waddr0(waddr0), .in0(in0),
      .load1(load1), .waddr1(waddr1), .in1(in1),
      .raddr_a(raddr_a), .raddr_b(raddr_b),
      .out_a(zr_a), .out_b(zr_b)
   );

   ldstr_reg_file #(.DEPTH(6)) u_d6 (
      .clk(clk), .clr(clr),
      .load0(load0), .waddr0(waddr0), .in0(in0),
      .load1(load1), .waddr1(waddr1), .in1(in1),
      .raddr_a(raddr_a), .raddr_b(raddr_b),
      .out_a(d6_a), .out_b(d6_b)
   );

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag,
                      input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic l0, input logic [2:0] a0,
                     input logic [7:0] d0,
                     input logic l1, input logic [2:0] a1,
                     input logic [7:0] d1);
      @(posedge clk);
      load0 = l0; waddr0 = a0; in0 = d0;
      load1 = l1; waddr1 = a1; in1 = d1;
      @(negedge clk);
      #1;
      load0 = 1'b0;
      load1 = 1'b0;
   endtask

   logic [7:0] d6_exp [6];

   initial begin
      checks = 0;
      failures = 0;
      clr = 1'b0;
      load0 = 1'b0; waddr0 = '0; in0 = '0;
      load1 = 1'b0; waddr1 = '0; in1 = '0;
      raddr_a = 3'd5; raddr_b = 3'd2;
      #2;
      chk("rst_df_a", df_a, 8'h00);
      chk("rst_d6_b", d6_b, 8'h00);
      @(posedge clk);
      clr = 1'b1;

      wr(1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 8'h00);
      chk("wr5_df", df_a, 8'h3C);
      chk("wr5_nb", nb_a, 8'h3C);
      wr(1'b0, 3'd5, 8'hFF, 1'b0, 3'd0, 8'h00);
      chk("hold5_df", df_a, 8'h3C);

      wr(1'b1, 3'd2, 8'h11, 1'b1, 3'd4, 8'h22);
      raddr_a = 3'd2; raddr_b = 3'd4;
      #1;
      chk("dual_r2", df_a, 8'h11);
      chk("dual_r4", df_b, 8'h22);
      chk("dual_nb_r4", nb_b, 8'h22);

      wr(1'b1, 3'd6, 8'h77, 1'b1, 3'd6, 8'h88);
      raddr_a = 3'd6;
      #1;
      chk("coll_df", df_a, 8'h77);
      chk("coll_nb", nb_a, 8'h77);

      wr(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'h10);
      @(posedge clk);
      load1 = 1'b1; waddr1 = 3'd1; in1 = 8'h99;
      raddr_b = 3'd1;
      #1;
      chk("byp_pre_df", df_b, 8'h99);
      chk("byp_pre_nb", nb_b, 8'h10);
      @(negedge clk);
      #1;
      load1 = 1'b0;
      #1;
      chk("byp_post_nb", nb_b, 8'h99);
      chk("byp_post_df", df_b, 8'h99);

      @(posedge clk);
      load0 = 1'b1; waddr0 = 3'd3; in0 = 8'hAB;
      load1 = 1'b1; waddr1 = 3'd3; in1 = 8'hCD;
      raddr_a = 3'd3;
      #1;
      chk("byp_prio", df_a, 8'hAB);
      @(negedge clk);
      #1;
      load0 = 1'b0; load1 = 1'b0;
      #1;
      chk("prio_store", nb_a, 8'hAB);

      @(posedge clk);
      load0 = 1'b1; waddr0 = 3'd0; in0 = 8'hFF;
      load1 = 1'b1; waddr1 = 3'd2; in1 = 8'h5E;
      raddr_a = 3'd0; raddr_b = 3'd2;
      #1;
      chk("zr_pre_a", zr_a, 8'h00);
      chk("zr_pre_b", zr_b, 8'h5E);
      chk("nz_pre_a", df_a, 8'hFF);
      @(negedge clk);
      #1;
      load0 = 1'b0; load1 = 1'b0;
      #1;
      chk("zr_post_a", zr_a, 8'h00);
      chk("zr_post_b", zr_b, 8'h5E);
      chk("nz_post_a", df_a, 8'hFF);

      @(posedge clk);
      load0 = 1'b1; waddr0 = 3'd7; in0 = 8'h5A;
      raddr_a = 3'd7;
      #1;
      chk("d6_oor_pre", d6_a, 8'h00);
      chk("d8_byp7", df_a, 8'h5A);
      @(negedge clk);
      #1;
      load0 = 1'b0;
      #1;
      chk("d6_oor_post", d6_a, 8'h00);
      chk("d8_r7", df_a, 8'h5A);
      raddr_a = 3'd6;
      #1;
      chk("d6_r6", d6_a, 8'h00);

      d6_exp[0] = 8'hFF; d6_exp[1] = 8'h99;
      d6_exp[2] = 8'h5E; d6_exp[3] = 8'hAB;
      d6_exp[4] = 8'h22; d6_exp[5] = 8'h3C;
      for (int i = 0; i < 6; i++) begin
         raddr_b = 3'(i);
         #1;
         chk($sformatf("d6_r%0d", i), d6_b, d6_exp[i]);
      end

      wr(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00);
      raddr_a = 3'd3;
      #1;
      chk("pre_rst_r3", df_a, 8'hA5);
      @(posedge clk);
      #1;
      clr = 1'b0;
      #1;
      chk("async_clr_df", df_a, 8'h00);
      chk("async_clr_nb", nb_a, 8'h00);
      load0 = 1'b1; waddr0 = 3'd3; in0 = 8'h66;
      #1;
      chk("rst_nobyp", df_a, 8'h00);
      @(negedge clk);
      #1;
      chk("rst_nowr", df_a, 8'h00);
      load0 = 1'b0;
      @(posedge clk);
      clr = 1'b1;
      #1;
      chk("rel_r3", df_a, 8'h00);
      chk("rel_nb_r3", nb_a, 8'h00);

      wr(1'b1, 3'd3, 8'h42, 1'b0, 3'd0, 8'h00);
      chk("first_wr", df_a, 8'h42);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
